coin_validator: RTL and testbench

Front-end stage of the vending machine. It converts the raw, bouncy coin-chute sensor into clean single-cycle coin events. It synchronises and debounces the sensor, measures how long each coin blocks the chute, and classifies the coin as ₹5, ₹10 or invalid. Its `coin_valid` / `coin_ten` outputs drive the vending FSM's `I` / `J` inputs directly.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/coin_debounce.sv | 52 +++++
 rtl/coin_validator.sv | 127 ++++++++++++
 tb/tb_coin_validator.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: validator FSM states, coin-type encoding
// and the default coin width bands used by coin_validator.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEASURE,
      ST_JAM,
      ST_GUARD
   } validator_state_e;

   // Coin-type encoding, identical to the vending FSM's J input.
   localparam logic COIN_5  = 1'b0;
   localparam logic COIN_10 = 1'b1;

   localparam int unsigned DEF_W5_MIN  = 20;
   localparam int unsigned DEF_W5_MAX  = 40;
   localparam int unsigned DEF_W10_MIN = 60;
   localparam int unsigned DEF_W10_MAX = 100;
   localparam int unsigned DEF_GUARD   = 16;
   localparam int unsigned DEF_CNT_W   = 8;

   function automatic logic in_band(input logic [31:0] w,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
      return (w >= lo) && (w <= hi);
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// Synchroniser chain plus stability counter: level_o follows the synchronised
// sensor only after it has differed from level_o for DEBOUNCE consecutive cycles.
module coin_debounce #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4
) (
   input  logic clk,
   input  logic reset_i,
   input  logic sense_i,
   output logic level_o
);

   localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      cnt_d   = '0;
      level_d = level_q;
      if (s != level_q) begin
         if (cnt_q == CW'(DEBOUNCE - 1)) begin
            level_d = s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values, independent of statement order.
      if (reset_i) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], sense_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/coin_validator.sv
// Coin chute front end: debounces the sensor, measures the blocked width and
// emits registered single-cycle accept/reject events for the vending FSM.
module coin_validator
   import vend_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned W5_MIN      = DEF_W5_MIN,
   parameter int unsigned W5_MAX      = DEF_W5_MAX,
   parameter int unsigned W10_MIN     = DEF_W10_MIN,
   parameter int unsigned W10_MAX     = DEF_W10_MAX,
   parameter int unsigned GUARD       = DEF_GUARD,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic coin_sense,
   input  logic accept_en,
   output logic coin_valid,
   output logic coin_ten,
   output logic coin_reject,
   output logic jam
);

   localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
   localparam logic [CNT_W-1:0] WIDTH_LIMIT = CNT_W'(W10_MAX);
   localparam logic [GW-1:0]    GUARD_LAST  = GW'(GUARD - 1);

   validator_state_e state_q, state_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic [GW-1:0]    guard_q, guard_d;
   logic             d, d_prev_q;
   logic             valid_q, valid_d;
   logic             ten_q, ten_d;
   logic             reject_q, reject_d;
   logic             jam_q, jam_d;
   logic             is_5, is_10;

   coin_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
   ) u_debounce (
      .clk    (clk),
      .reset_i(reset),
      .sense_i(coin_sense),
      .level_o(d)
   );

   assign is_5  = in_band(32'(width_q), W5_MIN, W5_MAX);
   assign is_10 = in_band(32'(width_q), W10_MIN, W10_MAX);

   always_comb begin
      state_d  = state_q;
      width_d  = width_q;
      guard_d  = guard_q;
      valid_d  = 1'b0;
      ten_d    = COIN_5;
      reject_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Only a genuine edge starts a coin; a level held over from GUARD does not.
            if (d && !d_prev_q) begin
               state_d = ST_MEASURE;
               width_d = CNT_W'(1);
            end
         end
         ST_MEASURE: begin
            if (d) begin
               if (width_q == WIDTH_LIMIT) state_d = ST_JAM;
               else                        width_d = width_q + 1'b1;
            end else begin
               if ((is_5 || is_10) && accept_en) begin
                  valid_d = 1'b1;
                  ten_d   = is_10 ? COIN_10 : COIN_5;
               end else begin
                  reject_d = 1'b1;
               end
               state_d = ST_GUARD;
               guard_d = '0;
            end
         end
         ST_JAM: begin
            if (!d) begin
               reject_d = 1'b1;
               state_d  = ST_GUARD;
               guard_d  = '0;
            end
         end
         ST_GUARD: begin
            if (guard_q == GUARD_LAST) state_d = ST_IDLE;
            else                       guard_d = guard_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      jam_d = (state_d == ST_JAM);
   end

   always_ff @(posedge clk) begin
      // NOTE: a synchronous reset clears every register here, including the
      // counters, so a coin interrupted by reset leaves nothing behind.
      if (reset) begin
         state_q  <= ST_IDLE;
         width_q  <= '0;
         guard_q  <= '0;
         d_prev_q <= 1'b0;
         valid_q  <= 1'b0;
         ten_q    <= 1'b0;
         reject_q <= 1'b0;
         jam_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         width_q  <= width_d;
         guard_q  <= guard_d;
         d_prev_q <= d;
         valid_q  <= valid_d;
         ten_q    <= ten_d;
         reject_q <= reject_d;
         jam_q    <= jam_d;
      end
   end

   assign coin_valid  = valid_q;
   assign coin_ten    = ten_q;
   assign coin_reject = reject_q;
   assign jam         = jam_q;

endmodule

// File: tb/tb_coin_validator.sv
// Scoreboard bench for coin_validator: stimulus pushes expected coin events,
// an independent monitor pops and compares them as the DUT emits pulses.
module tb_coin_validator;
   import vend_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic coin_sense = 1'b0;
   logic accept_en = 1'b1;
   logic coin_valid, coin_ten, coin_reject, jam;

   coin_validator dut (
      .clk        (clk),
      .reset      (reset),
      .coin_sense (coin_sense),
      .accept_en  (accept_en),
      .coin_valid (coin_valid),
      .coin_ten   (coin_ten),
      .coin_reject(coin_reject),
      .jam        (jam)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum {EV_5, EV_10, EV_REJ} ev_e;
   typedef struct {
      ev_e         kind;
      int unsigned at;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned jam_lo = 32'hFFFF_FFFF;
   int unsigned jam_hi = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Clean coin of n cycles; the event lands n+7 edges after the sensor rises.
   task automatic coin(input int n, input logic acc, input bit expect_ev, input ev_e kind);
      step();
      accept_en  = acc;
      coin_sense = 1'b1;
      if (expect_ev) sb.push_back('{kind, cyc + n + 7});
      repeat (n) step();
      coin_sense = 1'b0;
      repeat (30) step();
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check("valid_reject_exclusive", 32'(coin_valid && coin_reject), 0);
         check("ten_gated", 32'(coin_ten && !coin_valid), 0);
         check("jam_level", 32'(jam), 32'(cyc >= jam_lo && cyc <= jam_hi));
         if (coin_valid || coin_reject) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_event: valid=%0b reject=%0b ten=%0b, expected none (cycle %0d)",
                        coin_valid, coin_reject, coin_ten, cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("event_cycle", cyc, e.at);
               check("event_valid", 32'(coin_valid), 32'(e.kind != EV_REJ));
               check("event_ten", 32'(coin_ten), 32'(e.kind == EV_10));
            end
         end
      end
   end

   initial begin
      int unsigned e0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_valid", 32'(coin_valid), 0);
      check("reset_ten", 32'(coin_ten), 0);
      check("reset_reject", 32'(coin_reject), 0);
      check("reset_jam", 32'(jam), 0);

      // Plain 5-rupee coin, then disabled and glitch cases.
      coin(30, 1'b1, 1'b1, EV_5);
      coin(30, 1'b0, 1'b1, EV_REJ);
      coin(3, 1'b1, 1'b0, EV_REJ);

      // Band edges.
      coin(19,  1'b1, 1'b1, EV_REJ);
      coin(20,  1'b1, 1'b1, EV_5);
      coin(40,  1'b1, 1'b1, EV_5);
      coin(41,  1'b1, 1'b1, EV_REJ);
      coin(59,  1'b1, 1'b1, EV_REJ);
      coin(60,  1'b1, 1'b1, EV_10);
      coin(100, 1'b1, 1'b1, EV_10);

      // 10-rupee coin with bounce at both edges: effective width 82.
      step();
      e0 = cyc;
      accept_en = 1'b1;
      sb.push_back('{EV_10, e0 + 91});
      coin_sense = 1'b1;
      step(); coin_sense = 1'b0;
      step(); coin_sense = 1'b1;
      repeat (80) step();
      coin_sense = 1'b0;
      step(); coin_sense = 1'b1;
      step(); coin_sense = 1'b0;
      repeat (40) step();

      // Jam: 150-cycle block, then a short coin that falls inside GUARD.
      step();
      e0 = cyc;
      jam_lo = e0 + 107;
      jam_hi = e0 + 156;
      sb.push_back('{EV_REJ, e0 + 157});
      coin_sense = 1'b1;
      repeat (150) step();
      coin_sense = 1'b0;
      repeat (5) step();
      coin_sense = 1'b1;
      repeat (5) step();
      coin_sense = 1'b0;
      repeat (40) step();
      jam_lo = 32'hFFFF_FFFF;
      jam_hi = 0;

      // Reset held from 15 cycles into a 30-cycle coin until after it leaves.
      step();
      coin_sense = 1'b1;
      repeat (15) step();
      reset = 1'b1;
      step();
      @(negedge clk);
      check("midreset_valid", 32'(coin_valid), 0);
      check("midreset_ten", 32'(coin_ten), 0);
      check("midreset_reject", 32'(coin_reject), 0);
      check("midreset_jam", 32'(jam), 0);
      repeat (15) step();
      coin_sense = 1'b0;
      repeat (5) step();
      reset = 1'b0;
      repeat (40) step();

      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
